// File: rtl/msnw_tx_arb.sv
// msnw_tx_arb: msnw link master port.
// Merges NUM_CH packet sources, each with its own circular FIFO, onto one
// msnw link using round-robin arbitration. Honours xoff back-pressure,
// optionally generates even parity per launched packet, and logs parity
// errors reported back by the slave in a saturating counter.
module msnw_tx_arb #(
  parameter int PKT_WIDTH  = 64,
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                          clk,
  input  logic                          rstb,
  input  logic [NUM_CH-1:0]             in_valid,
  input  logic [NUM_CH*PKT_WIDTH-1:0]   in_pkt,
  output logic [NUM_CH-1:0]             in_ready,
  input  logic                          parity_en_cfg,
  output logic [PKT_WIDTH-1:0]          msnw_pkt,
  output logic                          valid,
  output logic                          parity_en,
  output logic                          msnw_par,
  output logic [$clog2(NUM_CH)-1:0]     grant_ch,
  input  logic                          xoff,
  input  logic                          parity_error,
  input  logic [PKT_WIDTH-1:0]          error_pkt,
  output logic [ERR_CNT_W-1:0]          err_cnt,
  output logic [PKT_WIDTH-1:0]          err_pkt_last
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CH_W:0]    NUM_CH_W = (CH_W+1)'(NUM_CH);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

  // Channel FIFO state
  logic [PKT_WIDTH-1:0] mem_q    [NUM_CH][FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q [NUM_CH];
  logic [PTR_W-1:0]     rd_ptr_q [NUM_CH];
  logic [CNT_W-1:0]     cnt_q    [NUM_CH];

  logic [NUM_CH-1:0]    push;
  logic [NUM_CH-1:0]    pop;
  logic [NUM_CH-1:0]    not_empty;

  // Arbitration
  logic [CH_W-1:0]      last_grant_q;
  logic [CH_W-1:0]      winner;
  logic [CH_W-1:0]      rr_idx;
  logic [CH_W:0]        rr_sum;
  logic                 found;
  logic                 launch;
  logic [PKT_WIDTH-1:0] head;

  // Link-side registers
  logic                 valid_q;
  logic [PKT_WIDTH-1:0] pkt_q;
  logic [CH_W-1:0]      grant_q;
  logic                 par_en_q;
  logic                 par_q;

  // Error log registers
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic [PKT_WIDTH-1:0] err_pkt_q;

  // Per-channel status from registered occupancy; ready never depends on a same-cycle pop
  always_comb begin
    in_ready  = '0;
    not_empty = '0;
    push      = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      in_ready[c]  = (cnt_q[c] != FULL_CNT);
      not_empty[c] = (cnt_q[c] != '0);
      push[c]      = in_valid[c] & in_ready[c];
    end
  end

  // Round-robin search over non-empty FIFOs starting just after the last grant
  always_comb begin
    winner = '0;
    found  = 1'b0;
    rr_sum = '0;
    rr_idx = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      rr_sum = {1'b0, last_grant_q} + (CH_W+1)'(i);
      if (rr_sum >= NUM_CH_W) begin
        rr_sum = rr_sum - NUM_CH_W;
      end
      rr_idx = rr_sum[CH_W-1:0];
      if (!found && not_empty[rr_idx]) begin
        found  = 1'b1;
        winner = rr_idx;
      end
    end
  end

  assign launch = found & ~xoff;
  assign head   = mem_q[winner][rd_ptr_q[winner]];

  // Only the winning channel pops, and only on an edge that actually launches
  always_comb begin
    pop = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      pop[c] = launch && (winner == CH_W'(c));
    end
  end

  // FIFO storage; left unreset because occupancy gates every read
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push[c]) begin
        mem_q[c][wr_ptr_q[c]] <= in_pkt[c*PKT_WIDTH +: PKT_WIDTH];
      end
    end
  end

  // FIFO pointers and occupancy; reset empties every channel
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (push[c]) begin
          wr_ptr_q[c] <= wr_ptr_q[c] + PTR_W'(1);
        end
        if (pop[c]) begin
          rd_ptr_q[c] <= rd_ptr_q[c] + PTR_W'(1);
        end
        if (push[c] && !pop[c]) begin
          cnt_q[c] <= cnt_q[c] + CNT_W'(1);
        end else if (!push[c] && pop[c]) begin
          cnt_q[c] <= cnt_q[c] - CNT_W'(1);
        end
      end
    end
  end

  // Launch register: packet fields hold when nothing launches, valid is a single-cycle pulse
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      valid_q      <= 1'b0;
      pkt_q        <= '0;
      grant_q      <= '0;
      par_en_q     <= 1'b0;
      par_q        <= 1'b0;
      last_grant_q <= LAST_CH;
    end else begin
      valid_q <= launch;
      if (launch) begin
        pkt_q        <= head;
        grant_q      <= winner;
        par_en_q     <= parity_en_cfg;
        par_q        <= parity_en_cfg & (^head);
        last_grant_q <= winner;
      end
    end
  end

  // Parity error log: counter saturates, captured packet always updates
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      err_cnt_q <= '0;
      err_pkt_q <= '0;
    end else if (parity_error) begin
      err_pkt_q <= error_pkt;
      if (err_cnt_q != '1) begin
        err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
      end
    end
  end

  assign valid        = valid_q;
  assign msnw_pkt     = pkt_q;
  assign grant_ch     = grant_q;
  assign parity_en    = par_en_q;
  assign msnw_par     = par_q;
  assign err_cnt      = err_cnt_q;
  assign err_pkt_last = err_pkt_q;

endmodule

// File: doc/msnw_tx_arb.md
# msnw_tx_arb

Parametrised message-network master port. It merges NUM_CH independent packet sources onto one msnw link. Each source has its own FIFO, and sources are served by round-robin arbitration. The block honours the link's xoff back-pressure, generates an optional even-parity bit, and logs parity errors reported back by the slave. It sits between on-chip packet producers and the msnw link, driving the master side of the link.

## Interface
- PKT_WIDTH, 64, msnw packet width in bits
- NUM_CH, 4, number of source channels (2..16)
- FIFO_DEPTH, 4, entries per channel FIFO (power of 2, at least 2)
- ERR_CNT_W, 16, width of the parity-error counter
- Clocking: one clock; reset is asynchronous and active-low.

Ports:
- clk  in  1  link clock; all logic is on its rising edge
- rstb  in  1  asynchronous active-low reset
- in_valid  in  NUM_CH  per-channel packet offer
- in_pkt  in  NUM_CH*PKT_WIDTH  channel c uses bits [c*PKT_WIDTH +: PKT_WIDTH]
- in_ready  out  NUM_CH  per-channel accept; equals FIFO not full
- parity_en_cfg  in  1  parity generation enable, sampled at each launch
- msnw_pkt  out  PKT_WIDTH  launched packet
- valid  out  1  msnw_pkt is valid this cycle
- parity_en  out  1  parity_en_cfg captured with the launched packet
- msnw_par  out  1  even parity of msnw_pkt when parity_en=1, else 0
- grant_ch  out  $clog2(NUM_CH)  channel of the current/last launched packet
- xoff  in  1  slave back-pressure
- parity_error  in  1  slave detected a parity error
- error_pkt  in  PKT_WIDTH  packet that caused parity_error
- err_cnt  out  ERR_CNT_W  saturating parity-error count
- err_pkt_last  out  PKT_WIDTH  last error_pkt captured

## Operation
- **Push:** on each edge, channel c pushes in_pkt[c] when in_valid[c] && in_ready[c].
  - in_ready[c] = !full[c], registered-state based, with no same-cycle pass-through.
  - When full, a pop in the same cycle does not enable a push; in_ready rises on the following cycle.
- **Arbitration:** round-robin over non-empty FIFOs.
  - The search starts at last_grant+1 and wraps NUM_CH-1 to 0.
  - last_grant resets to NUM_CH-1, so channel 0 wins first.
  - last_grant updates only on a launch.
- **Launch (each edge):**
  - If xoff is sampled 0 and any FIFO is non-empty: pop the winner's head and register valid=1, msnw_pkt=head, grant_ch=winner, parity_en=parity_en_cfg, msnw_par=parity_en_cfg ? ^head : 0.
  - Otherwise register valid=0. msnw_pkt, grant_ch, parity_en and msnw_par hold their previous values.
- **Throughput:** at most one packet per cycle. Back-to-back launches from different channels are allowed. A single channel alone gets one packet per cycle.
- **Error log:** on each edge with parity_error=1:
  - err_pkt_last <= error_pkt.
  - err_cnt increments, saturating at all-ones. At saturation it holds; err_pkt_last still updates.
- **FIFOs:** circular with read/write pointers. Occupancy counter width is $clog2(FIFO_DEPTH)+1. Pointers wrap FIFO_DEPTH-1 to 0.
- **Reset (rstb low, asynchronous, any time):**
  - All FIFOs are empty; queued packets are discarded.
  - valid=0, msnw_pkt=0, parity_en=0, msnw_par=0, grant_ch=0, err_cnt=0, err_pkt_last=0.
  - in_ready is all ones after reset.
  - A packet on the link mid-transfer is dropped; valid deasserts immediately.

## Timing
- **Latency:** a packet pushed at edge k can launch at edge k+1 at the earliest, so valid is high in the cycle after k+1. Minimum in_valid-to-valid latency is 2 edges.
- **xoff:**
  - xoff=1 sampled at edge k means no launch at k, so valid=0 after k.
  - The first launch after xoff falls occurs at the first edge where xoff is sampled 0.
  - No packet is lost or duplicated across xoff toggles.
- **valid:** high for exactly one cycle per packet, with no hold semantics. The slave must accept every valid cycle.
- **Error status:** err_cnt and err_pkt_last update one edge after parity_error is sampled.
- **Simultaneous events:**
  - Push into and pop from the same non-full FIFO in one cycle leaves occupancy unchanged.
  - An xoff-blocked edge neither pops nor advances last_grant.

## Test plan
- **Reset defaults:** assert rstb mid-stream with 3 packets queued in ch1 -> valid=0 immediately; all outputs 0; in_ready=4'b1111; no ch1 packets appear after release.
- **Round-robin:** NUM_CH=4, preload 2 packets in each channel, xoff=0 -> grant_ch sequence 0,1,2,3,0,1,2,3 on 8 consecutive valid cycles; payloads in per-channel FIFO order.
- **FIFO full and wrap:** push 5 packets into ch2 with xoff=1 -> in_ready[2] low after the 4th. Release xoff -> 4 packets out in order. Repeat 3 times to exercise pointer wrap with no corruption.
- **xoff toggle:** stream 10 packets from ch0 while toggling xoff 1,0,0,1,1,0 -> valid low exactly on the edges after xoff=1 samples; all 10 delivered once, in order.
- **Parity:** parity_en_cfg=1 with msnw_pkt=64'h1 -> msnw_par=1; with 64'h3 -> msnw_par=0. parity_en_cfg=0 -> msnw_par=0 and parity_en=0.
- **Error counter:** ERR_CNT_W=4, pulse parity_error 17 times with error_pkt=i -> err_cnt saturates at 15; err_pkt_last=16 after the last pulse.
